// File: rtl/mac_stream_pkg.sv
// Shared types for the MAC operand stream: operand widths, the operand triple
// and the sender state encoding.
package mac_stream_pkg;

    localparam int OPA_W = 8;
    localparam int OPB_W = 8;
    localparam int OPC_W = 16;

    typedef struct packed {
        logic [OPA_W-1:0] a;
        logic [OPB_W-1:0] b;
        logic [OPC_W-1:0] c;
    } operand_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ACTIVE      = 2'd1,
        WAIT_CREDIT = 2'd2,
        DRAIN       = 2'd3
    } sender_state_t;

    function automatic sender_state_t classify_state(
        input logic fifo_empty,
        input logic cred_zero,
        input logic cred_full
    );
        if (fifo_empty) begin
            return cred_full ? IDLE : DRAIN;
        end
        return cred_zero ? WAIT_CREDIT : ACTIVE;
    endfunction

endpackage

// File: rtl/mac_operand_fifo.sv
// First-word-fall-through FIFO of operand triples; the head is readable
// combinationally and a written entry appears at the head from the next cycle.
module mac_operand_fifo
    import mac_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  operand_t      wr_data,
    input  logic          rd_en,
    output operand_t      rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    operand_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Callers qualify wr_en with !full and rd_en with !empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/mac_operand_sender.sv
// Operand-side transmitter for the MAC stream: buffers operand triples and
// throttles transfers with credits returned by the MAC result handshake.
module mac_operand_sender
    import mac_stream_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [OPA_W-1:0] push_a,
    input  logic [OPB_W-1:0] push_b,
    input  logic [OPC_W-1:0] push_c,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [OPA_W-1:0] tx_a,
    output logic [OPB_W-1:0] tx_b,
    output logic [OPC_W-1:0] tx_c,
    input  logic             ret_valid,
    input  logic             ret_ready,
    output logic [3:0]       credits,
    output logic [CW-1:0]    fifo_count,
    output logic [15:0]      sent_count,
    output logic [1:0]       state,
    output logic             err_credit
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    operand_t      push_op, head_op;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt, fifo_cnt_next;
    logic          push_fire, tx_fire, ret_fire;

    logic [3:0]    credits_q, credits_d;
    logic [15:0]   sent_count_q, sent_count_d;
    sender_state_t state_q, state_d;
    logic          err_credit_q, err_credit_d;

    assign push_op    = '{a: push_a, b: push_b, c: push_c};
    assign push_ready = !reset && !fifo_full;
    assign tx_valid   = !reset && !fifo_empty && (credits_q != '0);
    assign push_fire  = push_valid && push_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign ret_fire   = ret_valid && ret_ready;

    mac_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_fire),
        .wr_data (push_op),
        .rd_en   (tx_fire),
        .rd_data (head_op),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    always_comb begin
        credits_d     = credits_q;
        err_credit_d  = err_credit_q;
        sent_count_d  = sent_count_q + 16'(tx_fire);
        // A transfer and a return in the same cycle cancel out.
        if (tx_fire && !ret_fire) begin
            credits_d = credits_q - 4'd1;
        end else if (ret_fire && !tx_fire) begin
            if (credits_q == CRED_MAX) begin
                err_credit_d = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end
        fifo_cnt_next = fifo_cnt + CW'(push_fire) - CW'(tx_fire);
        state_d = classify_state(fifo_cnt_next == '0, credits_d == '0,
                                 credits_d == CRED_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q    <= CRED_MAX;
            sent_count_q <= '0;
            state_q      <= IDLE;
            err_credit_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            sent_count_q <= sent_count_d;
            state_q      <= state_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign tx_a       = head_op.a;
    assign tx_b       = head_op.b;
    assign tx_c       = head_op.c;
    assign credits    = credits_q;
    assign fifo_count = fifo_cnt;
    assign sent_count = sent_count_q;
    assign state      = state_q;
    assign err_credit = err_credit_q;

endmodule

// File: tb/tb_mac_operand_sender.sv
// Directed and random checks of mac_operand_sender against a queue-based
// behavioural model of the operand stream and its credit accounting.
module tb_mac_operand_sender;
    import mac_stream_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [7:0]    push_a, push_b;
    logic [15:0]   push_c;
    logic          tx_valid, tx_ready;
    logic [7:0]    tx_a, tx_b;
    logic [15:0]   tx_c;
    logic          ret_valid, ret_ready;
    logic [3:0]    credits;
    logic [CW-1:0] fifo_count;
    logic [15:0]   sent_count;
    logic [1:0]    state;
    logic          err_credit;

    always #5 clk = ~clk;

    mac_operand_sender #(
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_a     (push_a),
        .push_b     (push_b),
        .push_c     (push_c),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_a       (tx_a),
        .tx_b       (tx_b),
        .tx_c       (tx_c),
        .ret_valid  (ret_valid),
        .ret_ready  (ret_ready),
        .credits    (credits),
        .fifo_count (fifo_count),
        .sent_count (sent_count),
        .state      (state),
        .err_credit (err_credit)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mq[$];
    int          mcred;
    int          msent;
    bit          merr;
    bit          last_push;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_state();
        if (mq.size() == 0) return (mcred == CREDITS) ? 0 : 3;
        return (mcred == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        mcred = CREDITS;
        msent = 0;
        merr  = 1'b0;
    endtask

    task automatic cyc(input bit rst, input bit pv, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] c, input bit tr, input bit rv, input bit rr);
        bit exp_pr, exp_tv, pushed, popped, ret;
        @(negedge clk);
        reset      = rst;
        push_valid = pv;
        push_a     = a;
        push_b     = b;
        push_c     = c;
        tx_ready   = tr;
        ret_valid  = rv;
        ret_ready  = rr;
        #1;
        exp_pr = !rst && (mq.size() < DEPTH);
        exp_tv = !rst && (mq.size() > 0) && (mcred > 0);
        chk("push_ready", 32'(push_ready), 32'(exp_pr));
        chk("tx_valid",   32'(tx_valid),   32'(exp_tv));
        chk("credits",    32'(credits),    32'(mcred));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("sent_count", 32'(sent_count), 32'(msent));
        chk("state",      32'(state),      32'(exp_state()));
        chk("err_credit", 32'(err_credit), 32'(merr));
        if (mq.size() > 0) chk("tx_head", {tx_a, tx_b, tx_c}, mq[0]);
        pushed = pv && exp_pr;
        popped = exp_tv && tr;
        ret    = rv && rr;
        @(posedge clk);
        last_push = pushed;
        if (rst) begin
            model_reset();
        end else begin
            if (popped) begin
                $display("tx #%0d a=%0d b=%0d c=%0d", msent, mq[0][31:24], mq[0][23:16], mq[0][15:0]);
                void'(mq.pop_front());
                msent = (msent + 1) % 65536;
            end
            if (pushed) mq.push_back({a, b, c});
            mcred = mcred - int'(popped) + int'(ret);
            if (mcred > CREDITS) begin
                mcred = CREDITS;
                merr  = 1'b1;
            end
        end
    endtask

    initial begin
        int idx;
        reset = 1'b1; push_valid = 1'b0; push_a = '0; push_b = '0; push_c = '0;
        tx_ready = 1'b0; ret_valid = 1'b0; ret_ready = 1'b0;
        model_reset();

        // Reset and idle
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Single operand round trip
        cyc(0, 1, 3, 5, 10, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);

        // Credit exhaustion with six operands, then one return
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'(i + 20), 8'(i + 40), 16'(i * 100), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Backpressure: fill while stalled, then drain in order
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 8'(idx + 1), 8'(idx + 11), 16'(idx + 1000), 0, 0, 0);
            if (last_push) idx++;
        end
        for (int k = 0; k < 12; k++) begin
            cyc(0, idx < 5, 8'(idx + 1), 8'(idx + 11), 16'(idx + 1000), 1, mcred < CREDITS, 1);
            if (last_push) idx++;
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous transfer and return, then a spurious return
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(i + 60), 8'(i + 70), 16'(i + 80), 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-operation with fifo_count=3, credits=1
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'(i + 90), 8'(i + 95), 16'(i + 99), 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'(i + 120), 8'(i + 130), 16'(i + 140), 0, 0, 0);
        cyc(1, 1, 7, 7, 7, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit rv;
            rv = (mcred < CREDITS) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                8'($urandom), 8'($urandom), 16'($urandom),
                $urandom_range(0, 3) != 0, rv, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
